// File: rtl/ccg_harness_pkg.sv
// Shared types and constants for the response-compaction harness.
// Optional compare feature is enabled in the top with `define CCG_RESP_CMP_EN.
package ccg_harness_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ccg_state_t;

    // x^10 + x^3 + 1
    localparam logic [9:0] CCG_DEF_POLY   = 10'h009;
    localparam int         CCG_MAX_SETTLE = 15;

endpackage

// File: rtl/ccg_misr.sv
// Multiple-input signature register: shift left, feed back the MSB through
// the tap mask, then xor in the parallel response word.
module ccg_misr #(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] POLY  = 10'h009
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_next;

    // next signature for one fold of d
    always_comb begin
        sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ d;
    end

    // fold register: seed tracks a constant, so the async load is a fixed value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= seed;
        end else if (clr) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/ccg_resp_compactor.sv
// Walks every input pattern of a combinational circuit under test and folds
// each response into a MISR signature.
// Optional macro CCG_RESP_CMP_EN adds golden_i / pass_o signature compare.
//
//   state | meaning
//   IDLE  | waiting for start, signature held
//   LOAD  | one cycle: signature <= SEED, pattern and hold counter cleared
//   RUN   | hold each pattern SETTLE_CYC+1 cycles, fold on the last one
//   DONE  | one cycle done pulse, signature final
module ccg_resp_compactor
    import ccg_harness_pkg::*;
#(
    parameter int               N_IN       = 3,
    parameter int               N_OUT      = 10,
    parameter logic [N_OUT-1:0] MISR_POLY  = CCG_DEF_POLY,
    parameter logic [N_OUT-1:0] SEED       = '0,
    parameter int               SETTLE_CYC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  x_o,
    input  logic [N_OUT-1:0] f_i,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] sig_o
`ifdef CCG_RESP_CMP_EN
    ,
    input  logic [N_OUT-1:0] golden_i,
    output logic             pass_o
`endif
);

    // hold counter is 4 bits, so out-of-range settings saturate
    localparam int              SETTLE_EFF = (SETTLE_CYC > CCG_MAX_SETTLE) ? CCG_MAX_SETTLE : SETTLE_CYC;
    localparam logic [3:0]      HOLD_LAST  = 4'(SETTLE_EFF);
    localparam logic [N_IN-1:0] X_LAST     = '1;

    ccg_state_t state;
    logic [3:0] hold;
    logic       misr_clr;
    logic       misr_en;
    logic       last_fold;

    // fold strobe on the last hold cycle of each pattern; seed load in LOAD
    always_comb begin
        misr_clr  = (state == LOAD);
        misr_en   = (state == RUN) && (hold == HOLD_LAST);
        last_fold = misr_en && (x_o == X_LAST);
    end

    ccg_misr #(
        .WIDTH (N_OUT),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .seed  (SEED),
        .en    (misr_en),
        .d     (f_i),
        .sig   (sig_o)
    );

    // sequencer: state, pattern counter, hold counter and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x_o   <= '0;
            hold  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    x_o   <= '0;
                    hold  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (hold == HOLD_LAST) begin
                        hold <= '0;
                        x_o  <= x_o + 1'b1;
                        if (x_o == X_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CCG_RESP_CMP_EN
    logic [N_OUT-1:0] sig_final;

    // value the signature takes on the last fold, so pass_o lines up with done
    always_comb begin
        sig_final = {sig_o[N_OUT-2:0], 1'b0} ^ (sig_o[N_OUT-1] ? MISR_POLY : '0) ^ f_i;
    end

    // verdict latched entering DONE, cleared when the next run is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_o <= 1'b0;
        end else if (state == IDLE && start) begin
            pass_o <= 1'b0;
        end else if (last_fold) begin
            pass_o <= (sig_final == golden_i);
        end
    end
`endif

endmodule

// File: tb/tb_ccg_resp_compactor.sv
// Bench for ccg_resp_compactor: three instances (default, SEED=10'h200,
// SETTLE_CYC=2), scoreboard of expected signatures checked at each done.
module tb_ccg_resp_compactor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [3];
    int         fmode [3];
    logic [2:0] x     [3];
    logic [9:0] f     [3];
    logic       busy  [3];
    logic       done  [3];
    logic [9:0] sig   [3];
`ifdef CCG_RESP_CMP_EN
    logic [9:0] golden [3];
    logic       pass   [3];
`endif

    localparam logic [9:0] SEED_OF   [3] = '{10'h000, 10'h200, 10'h000};
    localparam int         SETTLE_OF [3] = '{0, 0, 2};

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    function automatic logic [9:0] fgen(input int mode, input logic [2:0] xv);
        case (mode)
            1:       return 10'h001;
            2:       return {7'b0, xv};
            default: return 10'h000;
        endcase
    endfunction

    assign f[0] = fgen(fmode[0], x[0]);
    assign f[1] = fgen(fmode[1], x[1]);
    assign f[2] = fgen(fmode[2], x[2]);

    ccg_resp_compactor u_dut (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .x_o(x[0]), .f_i(f[0]),
        .busy(busy[0]), .done(done[0]), .sig_o(sig[0])
`ifdef CCG_RESP_CMP_EN
        , .golden_i(golden[0]), .pass_o(pass[0])
`endif
    );

    ccg_resp_compactor #(.SEED(10'h200)) u_seed (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .x_o(x[1]), .f_i(f[1]),
        .busy(busy[1]), .done(done[1]), .sig_o(sig[1])
`ifdef CCG_RESP_CMP_EN
        , .golden_i(golden[1]), .pass_o(pass[1])
`endif
    );

    ccg_resp_compactor #(.SETTLE_CYC(2)) u_settle (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .x_o(x[2]), .f_i(f[2]),
        .busy(busy[2]), .done(done[2]), .sig_o(sig[2])
`ifdef CCG_RESP_CMP_EN
        , .golden_i(golden[2]), .pass_o(pass[2])
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // independent signature model: x^10+x^3+1 over patterns 0..7
    function automatic logic [9:0] ref_sig(input logic [9:0] seed, input int mode);
        logic [9:0] s;
        s = seed;
        for (int p = 0; p < 8; p++) begin
            s = {s[8:0], 1'b0} ^ (s[9] ? 10'h009 : 10'h000) ^ fgen(mode, 3'(p));
        end
        return s;
    endfunction

    task automatic pop_check(input int k, input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, sig[k], e);
        end
    endtask

    task automatic wait_done(input int k, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done[k]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // one full run on instance k; optionally pokes start mid-run
    task automatic run(input int k, input int mode, input logic [9:0] lit,
                       input bit poke_start, input bit gold_ok);
        int b;
        bit seen;
        int s_cyc;
        logic [9:0] e;
        s_cyc = SETTLE_OF[k];
        e = ref_sig(SEED_OF[k], mode);
        fmode[k] = mode;
`ifdef CCG_RESP_CMP_EN
        golden[k] = gold_ok ? e : (e ^ 10'h001);
`endif
        @(negedge clk);
        start[k] = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start[k] = 1'b0;
        b = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (done[k]) begin
                seen = 1'b1;
            end else begin
                if (busy[k]) begin
                    if (mode == 2)
                        check_val("x_seq", 32'(x[k]), (b == 0) ? 0 : (b - 1) / (s_cyc + 1));
`ifdef CCG_RESP_CMP_EN
                    if (b == 1) check_val("pass_clr", 32'(pass[k]), 32'd0);
`endif
                    b++;
                end
                if (poke_start) start[k] = (b >= 3 && b < 5);
                @(negedge clk);
            end
        end
        start[k] = 1'b0;
        if (!seen) begin
            check_val("done_timeout", 32'd0, 32'd1);
        end else begin
            check_val("busy_cycles", b, 1 + 8 * (s_cyc + 1));
            check_val("busy_at_done", 32'(busy[k]), 32'd0);
            pop_check(k, "sig_sb");
            check_val("sig_lit", sig[k], lit);
            check_val("x_wrap", 32'(x[k]), 32'd0);
`ifdef CCG_RESP_CMP_EN
            check_val("pass", 32'(pass[k]), 32'(gold_ok));
`endif
            @(negedge clk);
            check_val("done_pulse", 32'(done[k]), 32'd0);
            check_val("sig_hold", sig[k], lit);
        end
    endtask

    initial begin
        bit ok;
        bit seen;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            fmode[k] = 0;
`ifdef CCG_RESP_CMP_EN
            golden[k] = 10'h000;
`endif
        end
        #22;
        check_val("rst_sig0", sig[0], 10'h000);
        check_val("rst_sig1", sig[1], 10'h200);
        check_val("rst_busy", 32'(busy[0]), 32'd0);
        check_val("rst_done", 32'(done[0]), 32'd0);
        check_val("rst_x", 32'(x[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 0, 10'h000, 1'b0, 1'b1);
        run(0, 1, 10'h0FF, 1'b0, 1'b1);
        run(0, 2, 10'h00F, 1'b1, 1'b1);
        run(0, 2, 10'h00F, 1'b0, 1'b0);
        run(1, 0, 10'h089, 1'b0, 1'b1);
        run(2, 2, 10'h00F, 1'b0, 1'b1);

        // start held high: two runs with a single IDLE cycle between them
        fmode[0] = 2;
`ifdef CCG_RESP_CMP_EN
        golden[0] = 10'h00F;
`endif
        @(negedge clk);
        start[0] = 1'b1;
        exp_q.push_back(ref_sig(10'h000, 2));
        exp_q.push_back(ref_sig(10'h000, 2));
        wait_done(0, ok);
        check_val("b2b_done1", 32'(ok), 32'd1);
        pop_check(0, "b2b_sig1");
        @(negedge clk);
        check_val("b2b_idle_gap", 32'(busy[0]), 32'd0);
        @(negedge clk);
        check_val("b2b_reload", 32'(busy[0]), 32'd1);
        start[0] = 1'b0;
        wait_done(0, ok);
        check_val("b2b_done2", 32'(ok), 32'd1);
        pop_check(0, "b2b_sig2");
        repeat (2) @(negedge clk);
        check_val("b2b_stop", 32'(busy[0]), 32'd0);

        // reset at RUN cycle 4 aborts the run
        @(negedge clk);
        start[0] = 1'b1;
        exp_q.push_back(ref_sig(10'h000, 2));
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        check_val("abort_sig_pre", sig[0], 10'h003);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_val("abort_sig", sig[0], 10'h000);
        check_val("abort_busy", 32'(busy[0]), 32'd0);
        check_val("abort_x", 32'(x[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done[0] || busy[0]) seen = 1'b1;
        end
        check_val("abort_no_done", 32'(seen), 32'd0);
        run(0, 2, 10'h00F, 1'b0, 1'b1);
`ifdef CCG_RESP_CMP_EN
        run(0, 2, 10'h00F, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
